// File: rtl/cache_trace_feeder.sv
// Trace feeder: buffers loader entries in a first-word-fall-through FIFO and
// streams them to the cache, counting issued reads and writes until the trace ends.
module cache_trace_feeder #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 48,
    parameter int unsigned CNT_W  = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_op,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic                       out_op,
    output logic [ADDR_W-1:0]          out_addr,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           issued_reads,
    output logic [CNT_W-1:0]           issued_writes,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       done
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;
    localparam int unsigned ENT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    logic [ENT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENT_W-1:0]   head;
    logic               push;
    logic               pop;

    // Handshakes and fall-through head presentation
    always_comb begin
        head      = mem[rd_ptr];
        in_ready  = ((state == IDLE) || (state == STREAM)) && (fifo_count < CW'(DEPTH));
        out_valid = (fifo_count != '0);
        out_op    = head[ADDR_W];
        out_addr  = head[ADDR_W-1:0];
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Entry storage needs no reset; pointers and occupancy gate visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_op, in_addr};
        end
    end

    // Pointers, occupancy, statistics and trace-phase FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            issued_reads  <= '0;
            issued_writes <= '0;
            done          <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (pop) begin
                if (!out_op && (issued_reads != '1)) begin
                    issued_reads <= issued_reads + CNT_W'(1);
                end
                if (out_op && (issued_writes != '1)) begin
                    issued_writes <= issued_writes + CNT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (push) begin
                        state <= in_last ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    if (push && in_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // No pushes in DRAIN, so the pop of the last entry empties the FIFO
                    if (pop && (fifo_count == CW'(1))) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_trace_feeder.sv
// Directed bench for cache_trace_feeder: queue scoreboard on the cache side plus
// hand-computed occupancy, handshake, counter and done expectations.
module tb_cache_trace_feeder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_op;
    logic [47:0] in_addr;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic        out_op;
    logic [47:0] out_addr;
    logic        out_ready;
    logic [11:0] issued_reads;
    logic [11:0] issued_writes;
    logic [3:0]  fifo_count;
    logic        done;

    int          n_cmp;
    int          n_err;
    int          n_pop;
    logic        last_acc;
    logic [48:0] q[$];

    cache_trace_feeder #(.DEPTH(8), .ADDR_W(48), .CNT_W(12)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_op         (in_op),
        .in_addr       (in_addr),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_op        (out_op),
        .out_addr      (out_addr),
        .out_ready     (out_ready),
        .issued_reads  (issued_reads),
        .issued_writes (issued_writes),
        .fifo_count    (fifo_count),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reset for one edge with the given handshake inputs held active
    task automatic do_reset(input logic iv, input logic ordy);
        reset     = 1'b1;
        in_valid  = iv;
        in_op     = 1'b0;
        in_addr   = 48'h0;
        in_last   = 1'b0;
        out_ready = ordy;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        q.delete();
        n_pop = 0;
    endtask

    // One clock: drive inputs, score handshakes at the falling edge, advance
    task automatic cyc(input logic v, input logic op, input logic [47:0] a,
                       input logic last, input logic ordy);
        logic [48:0] e;
        in_valid  = v;
        in_op     = op;
        in_addr   = a;
        in_last   = last;
        out_ready = ordy;
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("pop_unexpected", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                check("pop_addr", 64'(out_addr), 64'(e[47:0]));
                check("pop_op", 64'(out_op), 64'(e[48]));
                n_pop++;
            end
        end
        if (last_acc) q.push_back({op, a});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   idx;
        logic chk94;
        n_cmp = 0;
        n_err = 0;
        n_pop = 0;
        last_acc = 1'b0;
        reset = 1'b1;
        in_valid = 1'b0;
        in_op = 1'b0;
        in_addr = 48'h0;
        in_last = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset values
        do_reset(1'b0, 1'b0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_reads", 64'(issued_reads), 64'd0);
        check("rst_writes", 64'(issued_writes), 64'd0);

        // Three-entry trace streamed straight through
        cyc(1'b1, 1'b0, 48'h7fff493822b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 48'h7fff493822a8, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 48'h7f3035f6a7c0, 1'b1, 1'b1);
        check("t1_done_early", 64'(done), 64'd0);
        check("t1_count_pre", 64'(fifo_count), 64'd1);
        cyc(1'b0, 1'b0, 48'h0, 1'b0, 1'b1);
        check("t1_done", 64'(done), 64'd1);
        check("t1_reads", 64'(issued_reads), 64'd2);
        check("t1_writes", 64'(issued_writes), 64'd1);
        check("t1_in_ready", 64'(in_ready), 64'd0);
        check("t1_out_valid", 64'(out_valid), 64'd0);
        check("t1_pops", 64'(n_pop), 64'd3);
        cyc(1'b1, 1'b0, 48'h55, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 48'h56, 1'b0, 1'b1);
        check("t1_done_hold", 64'(done), 64'd1);
        check("t1_done_count", 64'(fifo_count), 64'd0);

        // Fill to full with the cache stalled
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 48'h1000 + 48'(i * 8), 1'b0, 1'b0);
        check("full_count", 64'(fifo_count), 64'd8);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head", 64'(out_addr), 64'h1000);
        check("full_out_valid", 64'(out_valid), 64'd1);
        cyc(1'b1, 1'b0, 48'hdead, 1'b0, 1'b0);
        check("ninth_count", 64'(fifo_count), 64'd8);
        check("ninth_head", 64'(out_addr), 64'h1000);
        cyc(1'b1, 1'b0, 48'hbeef, 1'b0, 1'b1);
        check("full_pop_no_push", 64'(last_acc), 64'd0);
        check("full_pop_count", 64'(fifo_count), 64'd7);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 48'h0, 1'b0, 1'b1);
        check("drain_to3", 64'(fifo_count), 64'd3);

        // Simultaneous push and pop at occupancy 3
        check("pp_head", 64'(out_addr), 64'h1028);
        cyc(1'b1, 1'b1, 48'h3000, 1'b0, 1'b1);
        check("pp_count", 64'(fifo_count), 64'd3);
        check("pp_new_head", 64'(out_addr), 64'h1030);

        // Reset mid-trace with five entries buffered
        cyc(1'b1, 1'b0, 48'h3008, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 48'h3010, 1'b0, 1'b0);
        check("pre_rst_count", 64'(fifo_count), 64'd5);
        do_reset(1'b1, 1'b1);
        check("mid_rst_count", 64'(fifo_count), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_reads", 64'(issued_reads), 64'd0);
        check("mid_rst_writes", 64'(issued_writes), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        // A single last entry from IDLE must go straight to draining
        cyc(1'b1, 1'b1, 48'h4000, 1'b1, 1'b0);
        check("idle_last_in_ready", 64'(in_ready), 64'd0);
        check("idle_last_head", 64'(out_addr), 64'h4000);
        cyc(1'b0, 1'b0, 48'h0, 1'b0, 1'b1);
        check("idle_last_done", 64'(done), 64'd1);
        check("idle_last_writes", 64'(issued_writes), 64'd1);

        // Twenty entries with the cache ready every other cycle
        do_reset(1'b0, 1'b0);
        idx = 0;
        for (int c = 0; c < 200; c++) begin
            if (done) break;
            cyc(idx < 20, (idx % 3) == 0, 48'h2000_0000 + 48'(idx * 16), idx == 19, (c % 2) == 0);
            if (last_acc) idx++;
        end
        check("wrap_done", 64'(done), 64'd1);
        check("wrap_pops", 64'(n_pop), 64'd20);
        check("wrap_reads", 64'(issued_reads), 64'd13);
        check("wrap_writes", 64'(issued_writes), 64'd7);
        check("wrap_count", 64'(fifo_count), 64'd0);

        // Read counter saturation
        do_reset(1'b0, 1'b0);
        idx = 0;
        chk94 = 1'b0;
        for (int c = 0; c < 4300 && n_pop < 4097; c++) begin
            cyc(idx < 4097, 1'b0, 48'(idx) * 48'd8, 1'b0, 1'b1);
            if (last_acc) idx++;
            if (n_pop == 4094 && !chk94) begin
                check("sat_4094", 64'(issued_reads), 64'd4094);
                chk94 = 1'b1;
            end
        end
        check("sat_seen_4094", 64'(chk94), 64'd1);
        check("sat_pops", 64'(n_pop), 64'd4097);
        check("sat_reads", 64'(issued_reads), 64'd4095);
        check("sat_writes", 64'(issued_writes), 64'd0);
        check("sat_not_done", 64'(done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_trace_feeder.md
CACHE_TRACE_FEEDER -- requirements
Module: cache_trace_feeder

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the FIFO entry count (power of two, 2..16).
REQ-002 Parameter ADDR_W, default 48, SHALL set the access-address width.
REQ-003 Parameter CNT_W, default 12, SHALL set the statistics counter width.
REQ-004 Port clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 Port in_valid  in  1  SHALL indicate that a trace entry is offered by the loader.
REQ-007 Port in_op  in  1  SHALL be the entry operation: 0 = read, 1 = write.
REQ-008 Port in_addr  in  ADDR_W  SHALL be the entry byte address.
REQ-009 Port in_last  in  1  SHALL mark the final entry of the trace.
REQ-010 Port in_ready  out  1  SHALL indicate that the block accepts an entry this cycle.
REQ-011 Port out_valid  out  1  SHALL indicate that an access is presented to the cache.
REQ-012 Port out_op  out  1  SHALL be the presented operation (0 read, 1 write).
REQ-013 Port out_addr  out  ADDR_W  SHALL be the presented address, feeding the cache address input.
REQ-014 Port out_ready  in  1  SHALL indicate that the cache consumes the presented access this cycle.
REQ-015 Port issued_reads  out  CNT_W  SHALL count read accesses handed to the cache.
REQ-016 Port issued_writes  out  CNT_W  SHALL count write accesses handed to the cache.
REQ-017 Port fifo_count  out  $clog2(DEPTH)+1  SHALL report current FIFO occupancy.
REQ-018 Port done  out  1  SHALL indicate that the whole trace has been issued.

Function
REQ-019 Input handshake: push SHALL occur when in_valid && in_ready; output handshake: pop SHALL occur when out_valid && out_ready.
REQ-020 FIFO SHALL be first-word-fall-through: out_valid = (fifo_count != 0); out_op/out_addr = head entry, combinationally.
REQ-021 out_op and out_addr SHALL remain stable while out_valid && !out_ready.
REQ-022 The FSM SHALL have the states IDLE, STREAM, DRAIN, DONE; the reset state SHALL be IDLE.
REQ-023 in_ready SHALL be 1 only in IDLE or STREAM and only when fifo_count < DEPTH; a pop in the same cycle SHALL NOT raise in_ready when full.
REQ-024 IDLE->STREAM SHALL occur on a push with in_last=0; IDLE->DRAIN on a push with in_last=1.
REQ-025 STREAM->DRAIN SHALL occur on a push with in_last=1.
REQ-026 DRAIN->DONE SHALL occur on the pop that leaves fifo_count = 0.
REQ-027 DONE SHALL hold, with done=1 and in_ready=0, until reset.
REQ-028 A simultaneous push and pop SHALL leave fifo_count unchanged and preserve order.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH.
REQ-030 On a pop, issued_reads (out_op=0) or issued_writes (out_op=1) SHALL increment by 1 and saturate at 2^CNT_W-1.
REQ-031 A push with in_ready=0 SHALL NOT occur; in_valid with in_ready=0 SHALL be ignored without state change.

Reset
REQ-032 Reset SHALL put the FSM in IDLE, empty the FIFO, and zero both pointers.
REQ-033 Reset SHALL drive out_valid=0, fifo_count=0, issued_reads=0, issued_writes=0, done=0, and in_ready=1 in the following cycle.
REQ-034 Reset asserted mid-trace SHALL discard all buffered entries, with no pop reported that cycle; reset SHALL take priority over any push or pop.

Verification
REQ-035 After reset, push (r,0x7fff493822b0), (r,0x7fff493822a8), and (w,0x7f3035f6a7c0, last) with out_ready=1 -> cache sees the entries in order, issued_reads=2, issued_writes=1, done=1 one cycle after the third pop.
REQ-036 With out_ready=0, push 8 entries -> fifo_count=8, in_ready=0; then a ninth in_valid is not accepted; out_addr holds the first address.
REQ-037 At fifo_count=3, push and pop in the same cycle -> fifo_count stays 3 and the popped address equals the oldest entry.
REQ-038 Push 20 entries with out_ready toggling 1,0,1,0 -> all 20 appear in order across pointer wrap, and total issued = 20.
REQ-039 Assert reset with fifo_count=5 in STREAM -> next cycle fifo_count=0, out_valid=0, counters=0, state IDLE.
REQ-040 Preload issued_reads=4094 by issuing 4094 reads, then issue 3 more reads -> issued_reads=4095 (saturated).
